// File: rtl/soc_bus_fabric.sv
// rtl/soc_bus_fabric.sv - address decoder and wait-state generator for a CPU slave bus
//
// Purpose: decodes cpu_ab[15:12] into one of NSLOT slave chip selects, stalls the
// CPU for each slot's wait-state count, qualifies the write strobe to the completing
// cycle, and returns registered-select read data one cycle after completion.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   cpu_ab       in   CPU address (held while cpu_rdy=0)
//   cpu_we_n     in   CPU write enable, low-true
//   slave_do     in   packed slave read data, slot i at [DW*i +: DW]
//   cs_n         out  per-slot chip select, low-true, combinational from cpu_ab
//   slave_we_n   out  write strobe, low only in the completing cycle of a mapped access
//   cpu_di       out  CPU read data from the slot captured at completion
//   cpu_rdy      out  CPU ready, low stalls the CPU
//   unmapped_cnt out  saturating count of unmapped accesses
//
// Optional feature: define FABRIC_UNMAPPED_CNT_EN to build the unmapped-access
// counter; otherwise unmapped_cnt is tied to 8'h00.

module soc_bus_fabric #(
   parameter int                 NSLOT        = 4,
   parameter int                 DW           = 8,
   parameter logic [NSLOT*4-1:0] SLOT_PAGE    = 16'hF210,
   parameter logic [NSLOT*4-1:0] SLOT_WS      = 16'h0000,
   parameter logic [DW-1:0]      DEFAULT_DATA = 8'hFF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [15:0]         cpu_ab,
   input  logic                cpu_we_n,
   input  logic [NSLOT*DW-1:0] slave_do,
   output logic [NSLOT-1:0]    cs_n,
   output logic                slave_we_n,
   output logic [DW-1:0]       cpu_di,
   output logic                cpu_rdy,
   output logic [7:0]          unmapped_cnt
);

   localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            sel_vld_q, sel_vld_d;
   logic [IW-1:0]   sel_idx_q, sel_idx_d;

   logic            hit;
   logic [IW-1:0]   hit_idx;
   logic [3:0]      hit_ws;
   logic            done;

   // Only the page nibble takes part in decoding.
   logic            unused_addr;
   assign unused_addr = ^cpu_ab[11:0];

   // Scan from the top slot down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_ws  = 4'd0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (cpu_ab[15:12] == SLOT_PAGE[4*i +: 4]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
            hit_ws  = SLOT_WS[4*i +: 4];
         end
      end
   end

   always_comb begin
      cs_n = '1;
      for (int i = 0; i < NSLOT; i++) begin
         if (hit && (hit_idx == IW'(i))) begin
            cs_n[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         sel_vld_q <= 1'b0;
         sel_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_vld_q <= sel_vld_d;
         sel_idx_q <= sel_idx_d;
      end
   end

   // done marks the completing cycle of the current access (cpu_rdy high).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cpu_rdy   = 1'b1;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit && (hit_ws != 4'd0)) begin
               // The IDLE cycle itself is the first of the n stall cycles.
               cpu_rdy = 1'b0;
               cnt_d   = hit_ws - 4'd1;
               state_d = WAIT;
            end else begin
               done = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cpu_rdy = 1'b0;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   assign slave_we_n = (done && hit) ? cpu_we_n : 1'b1;

   always_comb begin
      sel_vld_d = sel_vld_q;
      sel_idx_d = sel_idx_q;
      if (done) begin
         sel_vld_d = hit;
         sel_idx_d = hit_idx;
      end
   end

   always_comb begin
      cpu_di = DEFAULT_DATA;
      if (sel_vld_q) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (sel_idx_q == IW'(i)) begin
               cpu_di = slave_do[DW*i +: DW];
            end
         end
      end
   end

`ifdef FABRIC_UNMAPPED_CNT_EN
   logic [7:0] unmapped_cnt_q, unmapped_cnt_d;

   always_comb begin
      unmapped_cnt_d = unmapped_cnt_q;
      if (done && !hit && (unmapped_cnt_q != 8'hFF)) begin
         unmapped_cnt_d = unmapped_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         unmapped_cnt_q <= 8'h00;
      end else begin
         unmapped_cnt_q <= unmapped_cnt_d;
      end
   end

   assign unmapped_cnt = unmapped_cnt_q;
`else
   assign unmapped_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb/tb_soc_bus_fabric.sv - scoreboard testbench for soc_bus_fabric

module tb_soc_bus_fabric;

   localparam int NSLOT = 4;
   localparam int DW    = 8;

   // Slot 3 shares page 1 with slot 1 so lowest-index priority is exercised.
   localparam logic [15:0] PAGE_P = 16'h1210;
   localparam logic [15:0] WS_P   = 16'h2130;

   int page_m [4] = '{0, 1, 2, 1};
   int ws_m   [4] = '{0, 3, 1, 2};

   logic              clk;
   logic              reset_n;
   logic [15:0]       cpu_ab;
   logic              cpu_we_n;
   logic [NSLOT*DW-1:0] slave_do;
   logic [NSLOT-1:0]  cs_n;
   logic              slave_we_n;
   logic [DW-1:0]     cpu_di;
   logic              cpu_rdy;
   logic [7:0]        unmapped_cnt;

   soc_bus_fabric #(
      .NSLOT        (NSLOT),
      .DW           (DW),
      .SLOT_PAGE    (PAGE_P),
      .SLOT_WS      (WS_P),
      .DEFAULT_DATA (8'hFF)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_ab       (cpu_ab),
      .cpu_we_n     (cpu_we_n),
      .slave_do     (slave_do),
      .cs_n         (cs_n),
      .slave_we_n   (slave_we_n),
      .cpu_di       (cpu_di),
      .cpu_rdy      (cpu_rdy),
      .unmapped_cnt (unmapped_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        we_n;
      int          slot;
      int          ws;
   } acc_t;

   acc_t q[$];

   int checks   = 0;
   int failures = 0;

   bit   mon_en    = 1'b0;
   bit   pend      = 1'b0;
   int   pend_slot = -1;
   int   stall     = 0;
   int   cnt_model = 0;
   acc_t h;
   logic [3:0] exp_cs;
   logic [7:0] exp_di;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_slot(input logic [15:0] a);
      for (int i = 0; i < NSLOT; i++) begin
         if (page_m[i] == int'(a[15:12])) return i;
      end
      return -1;
   endfunction

   // Monitor: checks read data / counter of the previous completion, then the current cycle.
   always @(negedge clk) begin
      if (pend) begin
         pend   = 1'b0;
         exp_di = (pend_slot >= 0) ? slave_do[pend_slot*DW +: DW] : 8'hFF;
         chk("cpu_di", 32'(cpu_di), 32'(exp_di));
         chk("unmapped_cnt", 32'(unmapped_cnt), 32'(cnt_model));
      end
      if (mon_en && (q.size() > 0)) begin
         h      = q[0];
         exp_cs = 4'hF;
         if (h.slot >= 0) exp_cs[h.slot] = 1'b0;
         chk("cs_n", 32'(cs_n), 32'(exp_cs));
         if (!cpu_rdy) begin
            stall++;
            chk("we_n_stall", 32'(slave_we_n), 32'd1);
            if (stall > h.ws) chk("stall_overrun", 32'(stall), 32'(h.ws));
         end else begin
            chk("stall_len", 32'(stall), 32'(h.ws));
            chk("we_n_done", 32'(slave_we_n), (h.slot >= 0) ? 32'(h.we_n) : 32'd1);
            void'(q.pop_front());
            stall     = 0;
            pend      = 1'b1;
            pend_slot = h.slot;
`ifdef FABRIC_UNMAPPED_CNT_EN
            if ((h.slot < 0) && (cnt_model < 255)) cnt_model++;
`endif
         end
      end
   end

   // Called just after a rising edge; returns just after the edge following completion.
   task automatic access(input logic [15:0] addr, input logic we_n);
      acc_t a;
      int   n;
      cpu_ab   = addr;
      cpu_we_n = we_n;
      slave_do = $urandom;
      a.addr   = addr;
      a.we_n   = we_n;
      a.slot   = ref_slot(addr);
      a.ws     = (a.slot >= 0) ? ws_m[a.slot] : 0;
      q.push_back(a);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_rdy && (n < 20));
      if (!cpu_rdy) begin
         checks++;
         failures++;
         $display("FAIL access_timeout actual=stuck required=cpu_rdy addr=%h", addr);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "access timeout");
      end
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ra;

   initial begin
      reset_n  = 1'b0;
      cpu_ab   = 16'h0123;
      cpu_we_n = 1'b1;
      slave_do = 32'h332211A5;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // First cycle after reset, then WS=0 read data one cycle later.
      @(negedge clk);
      chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
      chk("rst_we_n", 32'(slave_we_n), 32'd1);
      chk("rst_cpu_di", 32'(cpu_di), 32'hFF);
      chk("rst_cs_n", 32'(cs_n), 32'hE);
      chk("rst_unmapped", 32'(unmapped_cnt), 32'd0);
      @(negedge clk);
      chk("ws0_read_di", 32'(cpu_di), 32'hA5);

      // Reset asserted in WAIT of a WS=3 access: stall count restarts.
      @(posedge clk); #1;
      cpu_ab = 16'h1040;
      @(negedge clk);
      chk("wait_t0_rdy", 32'(cpu_rdy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      chk("wait_t1_rdy", 32'(cpu_rdy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_wait_rdy", 32'(cpu_rdy), (k < 3) ? 32'd0 : 32'd1);
         chk("rst_wait_cs", 32'(cs_n), 32'hD);
         if (k == 0) begin
            chk("rst_wait_di", 32'(cpu_di), 32'hFF);
            chk("rst_wait_unmapped", 32'(unmapped_cnt), 32'd0);
         end
      end
      @(posedge clk); #1;

      mon_en = 1'b1;
      access(16'h0123, 1'b1);
      access(16'h1040, 1'b1);
      access(16'h1000, 1'b0);
      access(16'h5000, 1'b1);
      access(16'h2ABC, 1'b0);
      access(16'h3000, 1'b0);
      access(16'h1FFF, 1'b0);
      access(16'h0000, 1'b0);

      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         if ($urandom_range(0, 3) != 0) ra[15:12] = 4'($urandom_range(0, 4));
         access(ra, 1'($urandom));
      end

      for (int i = 0; i < 300; i++) begin
         access(16'h5000, 1'b1);
      end
      access(16'h7123, 1'b0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter NSLOT, default 4: number of slave slots, legal range 1..8.
REQ-002 Parameter DW, default 8: data width in bits.
REQ-003 Parameter SLOT_PAGE, default 16'hF210: packed NSLOT*4 bits; bits [4i+3:4i] give the 4 kB page (cpu_ab[15:12]) of slot i.
REQ-004 Parameter SLOT_WS, default 16'h0000: packed NSLOT*4 bits; bits [4i+3:4i] give the wait-state count of slot i, 0..15.
REQ-005 Parameter DEFAULT_DATA, default 8'hFF: read data returned for unmapped addresses.
REQ-006 clk  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  reset, synchronous and active-low.
REQ-008 cpu_ab  in  16  CPU address; held stable by the CPU while cpu_rdy=0.
REQ-009 cpu_we_n  in  1  CPU write enable, low-true.
REQ-010 slave_do  in  NSLOT*DW  packed slave read data; slot i occupies [DW*i+DW-1:DW*i].
REQ-011 cs_n  out  NSLOT  per-slot chip select, low-true.
REQ-012 slave_we_n  out  1  qualified write strobe to slaves, low-true.
REQ-013 cpu_di  out  DW  CPU read data.
REQ-014 cpu_rdy  out  1  CPU ready; low stalls the CPU.
REQ-015 unmapped_cnt  out  8  count of unmapped accesses (see Configuration).

Function
REQ-016 Decode: slot i is hit when cpu_ab[15:12] equals page i; when several slots share a page, the lowest index wins; no hit means unmapped.
REQ-017 cs_n[i] is low (combinational) for every cycle the current address hits slot i, including wait cycles; all other bits are high.
REQ-018 FSM states are IDLE and WAIT, with a 4-bit down-counter cnt.
REQ-019 IDLE, hit with WS=0 or unmapped: cpu_rdy=1; the access completes this cycle; stay in IDLE.
REQ-020 IDLE, hit with WS=n>0: cpu_rdy=0; cnt<=n-1; go to WAIT.
REQ-021 WAIT: if cnt>0, cpu_rdy=0 and cnt<=cnt-1; if cnt==0, cpu_rdy=1, the access completes, and the FSM returns to IDLE.
REQ-022 cpu_rdy is therefore low for exactly n consecutive cycles for an n-wait slot.
REQ-023 slave_we_n = cpu_we_n only in the completing cycle of a mapped access; otherwise it is 1, so each write strobes exactly once.
REQ-024 On the completing cycle, a registered select captures the slot index, or unmapped; cpu_di = slave_do[selected slot], or DEFAULT_DATA, from the following cycle onward.
REQ-025 Read latency is 1 cycle after the completing cycle; this matches synchronous-read slaves.
REQ-026 Back-to-back accesses: a new address in the cycle after completion is decoded in IDLE with no bubble.
REQ-027 Writes to unmapped addresses are dropped: no cs_n or slave_we_n activity.

Reset
REQ-028 While reset_n=0 at a clock edge: state<=IDLE, cnt<=0, select<=unmapped, unmapped_cnt<=0.
REQ-029 Outputs in the cycle after reset: cpu_rdy=1, slave_we_n=1, cpu_di=DEFAULT_DATA; cs_n follows the decode.
REQ-030 Reset asserted during WAIT abandons the access; the first access after reset restarts its full wait count.

Configuration
REQ-031 With macro FABRIC_UNMAPPED_CNT_EN defined: unmapped_cnt increments once per unmapped access (counted on its completing cycle) and saturates at 8'hFF.
REQ-032 Without FABRIC_UNMAPPED_CNT_EN: unmapped_cnt is constant 8'h00 and no counter logic is present.

Verification
REQ-033 Read at 16'h0123, slot 0 (WS=0), slave_do slot0=8'hA5 -> cs_n=4'b1110 and cpu_rdy=1 in cycle t; cpu_di=8'hA5 in cycle t+1.
REQ-034 SLOT_WS slot 1=3; read at 16'h1040 -> cpu_rdy low for cycles t..t+2 and high at t+3; cs_n[1]=0 for cycles t..t+3; cpu_di valid at t+4.
REQ-035 Write at 16'h1000 with WS=3 -> slave_we_n low only in cycle t+3, exactly one pulse.
REQ-036 Read at 16'h5000 (unmapped) -> cs_n=4'b1111, cpu_rdy=1, cpu_di=8'hFF next cycle; with FABRIC_UNMAPPED_CNT_EN, unmapped_cnt goes 0->1, and after 300 such accesses reads 8'hFF.
REQ-037 Reset asserted at t+1 of a WS=3 access, released at t+2 with the same address held -> cpu_rdy low 3 cycles again starting at t+2; unmapped_cnt=0.
REQ-038 SLOT_PAGE=16'h1110 (slots 1-3 all page 1); read at 16'h1000 -> only cs_n[1]=0, and data comes from slot 1.
